recieve: RTL and testbench

RECIEVE -- requirements
Module: recieve

---
 rtl/recieve_pkg.sv | 42 ++++
 rtl/recieve_baud_cnt.sv | 40 ++++
 rtl/recieve.sv | 170 +++++++++++++++++
 tb/tb_recieve.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/recieve_pkg.sv
// Shared definitions for the 8N1 UART receiver: baud table, bit-period
// divider helper and FSM state encoding.
`timescale 1ns/1ps
package recieve_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned BAUD_CODE0 = 32'd115200;
  localparam int unsigned BAUD_CODE1 = 32'd57600;
  localparam int unsigned BAUD_CODE2 = 32'd38400;
  localparam int unsigned BAUD_CODE3 = 32'd19200;
  localparam int unsigned BAUD_CODE4 = 32'd9600;
  localparam int unsigned BAUD_CODE5 = 32'd230400;
  localparam int unsigned BAUD_CODE6 = 32'd460800;
  localparam int unsigned BAUD_CODE7 = 32'd921600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit for a baud code; only ever evaluated at elaboration time.
  function automatic logic [CNT_W-1:0] bit_cycles(input logic [2:0] code,
                                                  input int unsigned clk_freq);
    int unsigned baud;
    case (code)
      3'd0:    baud = BAUD_CODE0;
      3'd1:    baud = BAUD_CODE1;
      3'd2:    baud = BAUD_CODE2;
      3'd3:    baud = BAUD_CODE3;
      3'd4:    baud = BAUD_CODE4;
      3'd5:    baud = BAUD_CODE5;
      3'd6:    baud = BAUD_CODE6;
      3'd7:    baud = BAUD_CODE7;
      default: baud = BAUD_CODE0;
    endcase
    return CNT_W'(clk_freq / baud);
  endfunction

endpackage

// File: rtl/recieve_baud_cnt.sv
// Bit-period counter: wraps every `period` clocks while running and flags
// the half-period and full-period points relative to the last clear.
`timescale 1ns/1ps
module recieve_baud_cnt
  import recieve_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic             half_tick,
  output logic             full_tick
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] half_s;

  assign half_s    = {1'b0, period[CNT_W-1:1]};
  assign half_tick = run & (cnt_r == (half_s - CNT_W'(1)));
  assign full_tick = run & (cnt_r == (period - CNT_W'(1)));

  // Period counter, restarted by clr and held while the receiver is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (run) begin
      if (full_tick) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/recieve.sv
// 8N1 UART receiver with selectable baud rate, mid-bit sampling and
// framing-error rejection; Data/rx_done are registered outputs.
`timescale 1ns/1ps
module recieve
  import recieve_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [2:0] Baud_set,
  input  logic       uart_rx,
  output logic [7:0] Data,
  output logic       rx_done
);

  localparam logic [CNT_W-1:0] DIV0 = bit_cycles(3'd0, CLK_FREQ);
  localparam logic [CNT_W-1:0] DIV1 = bit_cycles(3'd1, CLK_FREQ);
  localparam logic [CNT_W-1:0] DIV2 = bit_cycles(3'd2, CLK_FREQ);
  localparam logic [CNT_W-1:0] DIV3 = bit_cycles(3'd3, CLK_FREQ);
  localparam logic [CNT_W-1:0] DIV4 = bit_cycles(3'd4, CLK_FREQ);
  localparam logic [CNT_W-1:0] DIV5 = bit_cycles(3'd5, CLK_FREQ);
  localparam logic [CNT_W-1:0] DIV6 = bit_cycles(3'd6, CLK_FREQ);
  localparam logic [CNT_W-1:0] DIV7 = bit_cycles(3'd7, CLK_FREQ);

  rx_state_t        state_r;
  rx_state_t        state_nxt_s;
  logic [1:0]       sync_r;
  logic [1:0]       flush_r;
  logic             prev_r;
  logic             rx_s;
  logic             fall_s;
  logic [CNT_W-1:0] div_sel_s;
  logic [CNT_W-1:0] div_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             cnt_clr_s;
  logic             latch_s;
  logic             shift_en_s;
  logic             load_s;
  logic             half_tick_s;
  logic             full_tick_s;

  assign rx_s   = sync_r[1];
  assign fall_s = prev_r & ~rx_s;

  // Divider lookup for the currently presented baud code.
  always_comb begin
    div_sel_s = DIV0;
    case (Baud_set)
      3'd0:    div_sel_s = DIV0;
      3'd1:    div_sel_s = DIV1;
      3'd2:    div_sel_s = DIV2;
      3'd3:    div_sel_s = DIV3;
      3'd4:    div_sel_s = DIV4;
      3'd5:    div_sel_s = DIV5;
      3'd6:    div_sel_s = DIV6;
      3'd7:    div_sel_s = DIV7;
      default: div_sel_s = DIV0;
    endcase
  end

  // Line synchronizer and edge history. prev_r only follows the line once the
  // reset ones have flushed, so a line held low across reset is not an edge.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync_r  <= 2'b11;
      flush_r <= 2'b00;
      prev_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], uart_rx};
      flush_r <= {flush_r[0], 1'b1};
      prev_r  <= flush_r[1] ? rx_s : 1'b0;
    end
  end

  recieve_baud_cnt u_baud_cnt (
    .clk       (sysclk),
    .rst       (rst),
    .clr       (cnt_clr_s),
    .run       (state_r != ST_IDLE),
    .period    (div_r),
    .half_tick (half_tick_s),
    .full_tick (full_tick_s)
  );

  // FSM state register.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    latch_s     = 1'b0;
    shift_en_s  = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s = ST_START;
          cnt_clr_s   = 1'b1;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (half_tick_s) begin
          if (rx_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
            cnt_clr_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (full_tick_s) begin
          shift_en_s  = 1'b1;
          state_nxt_s = (bit_cnt_r == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (full_tick_s) begin
          load_s      = rx_s;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Baud latch, bit assembly and registered outputs.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      div_r     <= DIV0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      Data      <= 8'h00;
      rx_done   <= 1'b0;
    end else begin
      if (latch_s) begin
        div_r     <= div_sel_s;
        bit_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
        shift_r   <= {rx_s, shift_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      rx_done <= load_s;
      if (load_s) begin
        Data <= shift_r;
      end
    end
  end

endmodule

// File: tb/tb_recieve.sv
// Self-checking bench for recieve: directed scenarios plus randomized frames
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_recieve;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [2:0] Baud_set;
  logic       uart_rx;
  logic [7:0] Data;
  logic       rx_done;

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         done_cnt     = 0;
  logic [7:0] done_data    = 8'h00;
  time        done_time    = 0;
  int         base_done    = 0;
  time        t_start      = 0;
  logic [7:0] exp_data     = 8'h00;

  recieve #(.CLK_FREQ(50_000_000)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .Baud_set (Baud_set),
    .uart_rx  (uart_rx),
    .Data     (Data),
    .rx_done  (rx_done)
  );

  always #10 sysclk = ~sysclk;

  // Every high cycle of rx_done counts, so a stretched pulse shows up as extra.
  always @(negedge sysclk) begin
    if (rx_done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      done_data <= Data;
      done_time <= $time;
    end
  end

  initial begin
    #1_950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int spec_cycles(input logic [2:0] code);
    case (code)
      3'd0:    return 434;
      3'd1:    return 868;
      3'd2:    return 1302;
      3'd3:    return 2604;
      3'd4:    return 5208;
      3'd5:    return 217;
      3'd6:    return 108;
      default: return 54;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gap(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  // Sends one frame at the rate of `code`; leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic [2:0] code,
                            input logic stop_bit, input logic chg);
    int         p;
    logic [9:0] bits;
    p        = spec_cycles(code);
    Baud_set = code;
    @(negedge sysclk);
    bits      = {stop_bit, b, 1'b0};
    base_done = done_cnt;
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      if (i == 0) t_start = $time;
      if (i == 1 && chg) Baud_set = 3'($urandom_range(0, 7));
      repeat (p) @(negedge sysclk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b,
                             input logic good, input int p);
    int     dn;
    longint lat;
    longint nom;
    longint diff;
    dn = done_cnt - base_done;
    if (good) exp_data = b;
    check({tag, "_pulses"}, 64'(dn), good ? 64'd1 : 64'd0);
    check({tag, "_data"}, 64'(Data), 64'(exp_data));
    if (good) begin
      check({tag, "_capt"}, 64'(done_data), 64'(b));
      lat  = longint'(done_time - t_start);
      nom  = 64'd40 + 64'd190 * longint'(p);
      diff = (lat > nom) ? (lat - nom) : (nom - lat);
      check({tag, "_lat"}, 64'(diff <= 64'd30), 64'd1);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [2:0] code;
    logic       good;
    logic       chg;
    int         p;

    rst      = 1'b0;
    uart_rx  = 1'b1;
    Baud_set = 3'd0;
    repeat (5) @(negedge sysclk);
    check("reset_data", 64'(Data), 64'h00);
    check("reset_done", 64'(rx_done), 64'd0);
    rst = 1'b1;
    gap(10);

    // 0xAB then 0xCD back to back at 115200
    send_frame(8'hAB, 3'd0, 1'b1, 1'b0);
    check_frame("ab", 8'hAB, 1'b1, 434);
    gap(5);
    send_frame(8'hCD, 3'd0, 1'b1, 1'b0);
    check_frame("cd", 8'hCD, 1'b1, 434);
    gap(20);

    // short low glitch on the idle line
    base_done = done_cnt;
    uart_rx   = 1'b0;
    repeat (5) @(negedge sysclk);
    gap(484);
    check("glitch_pulses", 64'(done_cnt - base_done), 64'd0);
    check("glitch_data", 64'(Data), 64'(exp_data));

    // framing error, line held low afterwards, then a good frame
    send_frame(8'h3C, 3'd5, 1'b0, 1'b0);
    repeat (434) @(negedge sysclk);
    check_frame("ferr", 8'h3C, 1'b0, 217);
    gap(217);
    send_frame(8'h96, 3'd5, 1'b1, 1'b0);
    check_frame("after_ferr", 8'h96, 1'b1, 217);
    gap(10);

    // reset in the middle of a frame, released while the line is low
    Baud_set  = 3'd6;
    base_done = done_cnt;
    uart_rx   = 1'b0;
    repeat (108) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (108) @(negedge sysclk);
    uart_rx = 1'b0;
    repeat (54) @(negedge sysclk);
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
    check("midrst_data", 64'(Data), 64'h00);
    check("midrst_done", 64'(rx_done), 64'd0);
    exp_data = 8'h00;
    rst      = 1'b1;
    repeat (108) @(negedge sysclk);
    gap(216);
    check("midrst_pulses", 64'(done_cnt - base_done), 64'd0);
    check("midrst_hold", 64'(Data), 64'h00);
    send_frame(8'hA5, 3'd6, 1'b1, 1'b0);
    check_frame("after_rst", 8'hA5, 1'b1, 108);
    gap(10);

    // randomized frames at the faster rates, some with bad stop bits and
    // Baud_set disturbed mid-frame
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      code = 3'($urandom_range(5, 7));
      good = ($urandom_range(0, 3) != 0);
      chg  = 1'($urandom_range(0, 1));
      p    = spec_cycles(code);
      send_frame(b, code, good, chg);
      check_frame($sformatf("rnd%0d", n), b, good, p);
      gap(int'($urandom_range(2, 40)));
    end

    // 0x55 at 9600
    send_frame(8'h55, 3'd4, 1'b1, 1'b0);
    check_frame("b9600", 8'h55, 1'b1, 5208);
    gap(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
